// File: rtl/miner_pkg.sv
// miner_pkg: widths and receiver state encoding shared by the work-packet path
package miner_pkg;
  localparam int PAYLOAD_BYTES = 44;
  localparam int MIDSTATE_W = 256;
  localparam int DATA_TAIL_W = 96;
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} rx_state_t;
endpackage

// File: rtl/rx_byte_strobe.sv
// rx_byte_strobe: one-cycle strobe on the rising edge of the UART byte-available level
module rx_byte_strobe (
  input  logic clk,
  input  logic reset,
  input  logic rx_ready,
  output logic stb
);
  logic prev;
  // history resets high so a level already present at reset release is not a byte
  always_ff @(posedge clk) prev <= !reset ? 1'b1 : rx_ready;
  assign stb = rx_ready && !prev;
endmodule

// File: rtl/work_packet_rx.sv
// work_packet_rx: deframes sync + 44-byte work packets into midstate/data_tail
// WORK_PACKET_CHECKSUM_EN adds a trailing XOR checksum byte and CHECK state
module work_packet_rx
  import miner_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ready,
  output logic [MIDSTATE_W-1:0]  midstate,
  output logic [DATA_TAIL_W-1:0] data_tail,
  output logic                   work_valid,
  output logic                   chk_err,
  output logic                   timeout_err,
  output logic                   busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FRAME_W = MIDSTATE_W + DATA_TAIL_W;
`ifdef WORK_PACKET_CHECKSUM_EN
  localparam int ASM_W = FRAME_W;
`else
  localparam int ASM_W = FRAME_W - 8;  // last payload byte goes straight from rx_data
`endif
  rx_state_t state, next_state;
  logic stb, last, tmo, done;
  logic [5:0] cnt;
  logic [TW-1:0] timer;
  logic [ASM_W-1:0] asm_q;
  logic [FRAME_W-1:0] frame;
  rx_byte_strobe u_strobe (.clk, .reset, .rx_ready, .stb);
  assign last = cnt == 6'(PAYLOAD_BYTES - 1);
  assign tmo = state != IDLE && !stb && timer == TW'(TIMEOUT_CYCLES - 1);
`ifdef WORK_PACKET_CHECKSUM_EN
  logic [7:0] csum;
  logic bad;
  assign done = stb && state == CHECK && rx_data == csum;
  assign bad = stb && state == CHECK && rx_data != csum;
  assign frame = asm_q;
  always_ff @(posedge clk)
    if (!reset) begin
      csum <= '0;
      chk_err <= 1'b0;
    end else begin
      chk_err <= bad;
      csum <= stb && state == IDLE ? '0 : stb && state == PAYLOAD ? csum ^ rx_data : csum;
    end
`else
  assign done = stb && state == PAYLOAD && last;
  assign frame = {asm_q, rx_data};
  assign chk_err = 1'b0;
`endif
  always_ff @(posedge clk) state <= !reset ? IDLE : next_state;
  always_comb
    next_state = tmo || done || (stb && state == CHECK) ? IDLE
      : stb && state == IDLE && rx_data == SYNC_BYTE ? PAYLOAD
`ifdef WORK_PACKET_CHECKSUM_EN
      : stb && state == PAYLOAD && last ? CHECK
`endif
      : state;
  always_comb busy = state != IDLE;
  always_ff @(posedge clk)
    if (!reset) begin
      cnt <= '0;
      timer <= '0;
      asm_q <= '0;
      midstate <= '0;
      data_tail <= '0;
      work_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      work_valid <= done;
      timeout_err <= tmo;
      timer <= stb || state == IDLE ? '0 : timer + 1'b1;
      if (stb && state == IDLE) cnt <= '0;
      else if (stb && state == PAYLOAD) begin
        cnt <= last ? cnt : cnt + 1'b1;
        asm_q <= {asm_q[ASM_W-9:0], rx_data};
      end
      if (done) {midstate, data_tail} <= frame;
    end
endmodule
